frame_strobe_sequencer: RTL and testbench



---
 rtl/fabric_cfg_pkg.sv | 12 +
 rtl/frame_row_assembler.sv | 33 +++
 rtl/frame_strobe_sequencer.sv | 114 +++++++++++
 tb/tb_frame_strobe_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// fabric_cfg_pkg: shared sequencer state type, column defaults and index-width helper
// No ports; imported by frame_strobe_sequencer and frame_row_assembler.
package fabric_cfg_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, STROBE, HOLD, DONE} seq_state_t;
    localparam int MAX_FRAMES_PER_COL = 20;
    localparam int FRAME_BITS_PER_ROW = 32;
    localparam int NUM_ROWS           = 4;
    // Counter width for n positions; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/frame_row_assembler.sv
// frame_row_assembler: FrameData register bank, one word-wide row written per accepted word
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_row_idx       row selected by the current word
//   i_wr            write strobe (accepted handshake)
//   i_data          configuration word
//   o_frame_data    assembled frame, row 0 in the least significant word
module frame_row_assembler
    import fabric_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow = FRAME_BITS_PER_ROW,
    parameter int NumRows         = NUM_ROWS,
    parameter int RowW            = idx_width(NUM_ROWS)
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [RowW-1:0]                    i_row_idx,
    input  logic                               i_wr,
    input  logic [FrameBitsPerRow-1:0]         i_data,
    output logic [NumRows*FrameBitsPerRow-1:0] o_frame_data
);
    logic [NumRows-1:0][FrameBitsPerRow-1:0] r_rows;
    logic [NumRows-1:0]                      w_we;
    always_comb begin
        w_we = '0;
        for (int i = 0; i < NumRows; i++) w_we[i] = i_wr && (i_row_idx == RowW'(i));
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rows <= '0;
        else for (int i = 0; i < NumRows; i++) if (w_we[i]) r_rows[i] <= i_data;
    end
    assign o_frame_data = r_rows;
endmodule

// File: rtl/frame_strobe_sequencer.sv
// frame_strobe_sequencer: loads a tile column frame by frame and fires one one-hot FrameStrobe per frame
// Ports:
//   CLK, resetn   configuration clock, asynchronous active-low reset
//   start, abort  begin a column load (IDLE only) / cancel a load in progress
//   in_data, in_valid, in_ready  configuration word stream
//   FrameData     assembled frame presented to the column
//   FrameStrobe   one-hot frame write strobe
//   MODE          1 while configuring, 0 in operation
//   busy, done    not IDLE / one-cycle pulse after the last frame
module frame_strobe_sequencer
    import fabric_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = MAX_FRAMES_PER_COL,
    parameter int FrameBitsPerRow = FRAME_BITS_PER_ROW,
    parameter int NumRows         = NUM_ROWS
) (
    input  logic                               CLK,
    input  logic                               resetn,
    input  logic                               start,
    input  logic                               abort,
    input  logic [FrameBitsPerRow-1:0]         in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               MODE,
    output logic                               busy,
    output logic                               done
);
    localparam int FW = idx_width(MaxFramesPerCol);
    localparam int RW = idx_width(NumRows);
    seq_state_t                 r_state;
    logic [FW-1:0]              r_frame_idx;
    logic [RW-1:0]              r_row_idx;
    logic [MaxFramesPerCol-1:0] r_strobe;
    logic                       r_mode;
    logic                       r_done;
    logic                       w_accept;
    logic                       w_last_row;
    logic                       w_last_frame;
    assign w_accept     = in_valid && (r_state == LOAD);
    assign w_last_row   = r_row_idx == RW'(NumRows - 1);
    assign w_last_frame = r_frame_idx == FW'(MaxFramesPerCol - 1);
    assign in_ready     = r_state == LOAD;
    assign busy         = r_state != IDLE;
    assign FrameStrobe  = r_strobe;
    assign MODE         = r_mode;
    assign done         = r_done;
    // Strobe and done are registered so they last exactly one cycle and
    // are cleared by default on every edge.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_frame_idx <= '0;
            r_row_idx   <= '0;
            r_strobe    <= '0;
            r_mode      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_strobe <= '0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_state     <= LOAD;
                    r_frame_idx <= '0;
                    r_row_idx   <= '0;
                    r_mode      <= 1'b1;
                end
                LOAD: begin
                    // A word offered alongside abort is still written.
                    if (in_valid) r_row_idx <= w_last_row ? '0 : r_row_idx + RW'(1);
                    if (abort) begin
                        r_state <= IDLE;
                        r_mode  <= 1'b0;
                    end else if (in_valid && w_last_row) begin
                        r_state  <= STROBE;
                        r_strobe <= MaxFramesPerCol'(1) << r_frame_idx;
                    end
                end
                STROBE: begin
                    r_state <= abort ? IDLE : HOLD;
                    r_mode  <= !abort;
                end
                HOLD: if (abort) begin
                    r_state <= IDLE;
                    r_mode  <= 1'b0;
                end else if (w_last_frame) begin
                    r_state <= DONE;
                    r_mode  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state     <= LOAD;
                    r_frame_idx <= r_frame_idx + FW'(1);
                end
                default: begin
                    r_state <= IDLE;
                    r_mode  <= 1'b0;
                end
            endcase
        end
    end
    frame_row_assembler #(
        .FrameBitsPerRow(FrameBitsPerRow),
        .NumRows        (NumRows),
        .RowW           (RW)
    ) u_rows (
        .i_clk       (CLK),
        .i_rst_n     (resetn),
        .i_row_idx   (r_row_idx),
        .i_wr        (w_accept),
        .i_data      (in_data),
        .o_frame_data(FrameData)
    );
endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// tb_frame_strobe_sequencer: randomized and directed checks against a frame/word-count reference model
module tb_frame_strobe_sequencer;
    localparam int MF = 20;
    localparam int FB = 32;
    localparam int NR = 4;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;
    logic              start = 1'b0, abort = 1'b0, in_valid = 1'b0, in_ready;
    logic [FB-1:0]     in_data = '0;
    logic [NR*FB-1:0]  frame_data;
    logic [MF-1:0]     frame_strobe;
    logic              mode, busy, done;
    logic              s1_start = 1'b0, s1_abort = 1'b0, s1_valid = 1'b0, s1_ready;
    logic [FB-1:0]     s1_data = '0;
    logic [FB-1:0]     s1_fd;
    logic [1:0]        s1_strobe;
    logic              s1_mode, s1_busy, s1_done;
    frame_strobe_sequencer #(.MaxFramesPerCol(MF), .FrameBitsPerRow(FB), .NumRows(NR)) u_dut (
        .CLK(clk), .resetn(resetn), .start(start), .abort(abort), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .FrameData(frame_data),
        .FrameStrobe(frame_strobe), .MODE(mode), .busy(busy), .done(done)
    );
    frame_strobe_sequencer #(.MaxFramesPerCol(2), .FrameBitsPerRow(FB), .NumRows(1)) u_dut1 (
        .CLK(clk), .resetn(resetn), .start(s1_start), .abort(s1_abort), .in_data(s1_data),
        .in_valid(s1_valid), .in_ready(s1_ready), .FrameData(s1_fd),
        .FrameStrobe(s1_strobe), .MODE(s1_mode), .busy(s1_busy), .done(s1_done)
    );
    int checks = 0;
    int errors = 0;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Reference model: a load is "active"; m_post counts cycles since the
    // frame's last word (0 = still collecting words, 1 = strobe cycle,
    // 2 = hold cycle, 3 = done cycle after the final frame).
    bit                      m_active;
    int                      m_post, m_cnt, m_frame, m_words;
    logic [NR-1:0][FB-1:0]   m_rows;
    task automatic model_reset();
        m_active = 0; m_post = 0; m_cnt = 0; m_frame = 0; m_words = 0; m_rows = '0;
    endtask
    task automatic model_step(input bit s, input bit a, input bit v, input logic [FB-1:0] d);
        if (!m_active) begin
            if (s) begin m_active = 1; m_frame = 0; m_cnt = 0; m_post = 0; end
        end else if (m_post == 0) begin
            if (v) begin
                m_rows[m_cnt] = d; m_cnt++; m_words++;
                if (m_cnt == NR) begin m_cnt = 0; m_post = 1; end
            end
            if (a) m_active = 0;
        end else if (m_post == 1) begin
            if (a) m_active = 0; else m_post = 2;
        end else if (m_post == 2) begin
            if (a) m_active = 0;
            else if (m_frame == MF - 1) m_post = 3;
            else begin m_frame++; m_post = 0; end
        end else m_active = 0;
    endtask
    task automatic check_outputs();
        logic [MF-1:0] es;
        es = '0;
        if (m_active && m_post == 1) es[m_frame] = 1'b1;
        check("in_ready", in_ready, m_active && m_post == 0);
        check("strobe", frame_strobe, es);
        check("strobe_onehot0", $onehot0(frame_strobe), 1);
        check("mode", mode, m_active && m_post < 3);
        check("busy", busy, m_active);
        check("done", done, m_active && m_post == 3);
        check("frame_data", frame_data, m_rows);
    endtask
    task automatic cycle(input bit s, input bit a, input bit v, input logic [FB-1:0] d);
        start = s; abort = a; in_valid = v; in_data = d;
        model_step(s, a, v, d);
        @(negedge clk);
        check_outputs();
    endtask
    initial begin
        int n, done_at, guard, s7, f, ph;
        logic [1:0] es1;
        model_reset();
        @(negedge clk);
        check_outputs();
        resetn = 1'b1;
        // Full load with values 0..79
        cycle(1, 0, 0, '0);
        n = 1; done_at = 0;
        while (n < 200 && done_at == 0) begin
            if (done) done_at = n;
            if (frame_strobe[0]) check("frame0_data", frame_data, {32'd3, 32'd2, 32'd1, 32'd0});
            if (done_at == 0) begin cycle(0, 0, 1, FB'(m_words)); n++; end
        end
        check("done_cycle", done_at, 121);
        repeat (3) cycle(0, 0, 0, '0);
        // Backpressure gap after word 2
        cycle(1, 0, 0, '0);
        repeat (3) cycle(0, 0, 1, $urandom);
        repeat (5) cycle(0, 0, 0, '0);
        cycle(0, 0, 1, $urandom);
        check("gap_strobe0", frame_strobe, MF'(1));
        cycle(0, 0, 0, '0);
        cycle(0, 1, 0, '0);
        check("abort_hold_idle", busy, 0);
        // Abort in STROBE of frame 7, then restart
        cycle(1, 0, 0, '0);
        guard = 0; s7 = 0;
        while (m_active && guard < 300) begin
            cycle(0, m_active && m_post == 1 && m_frame == 7, 1, $urandom);
            if (frame_strobe[7]) s7++;
            guard++;
        end
        check("strobe7_len", s7, 1);
        check("abort_strobe_idle", busy, 0);
        repeat (2) cycle(0, 0, 0, '0);
        cycle(1, 0, 0, '0);
        repeat (NR) cycle(0, 0, 1, $urandom);
        check("restart_strobe0", frame_strobe, MF'(1));
        cycle(0, 1, 0, '0);
        cycle(0, 0, 0, '0);
        // Start ignored during LOAD, start+abort together in IDLE
        cycle(1, 0, 0, '0);
        repeat (2) cycle(0, 0, 1, $urandom);
        cycle(1, 0, 1, $urandom);
        cycle(0, 0, 1, $urandom);
        repeat (4) cycle(0, 0, 1, $urandom);
        cycle(0, 1, 0, '0);
        cycle(1, 1, 0, '0);
        check("start_abort_load", in_ready, 1);
        repeat (6) cycle(0, 0, 1, $urandom);
        cycle(0, 1, 0, '0);
        cycle(0, 0, 0, '0);
        // Asynchronous reset during STROBE
        cycle(1, 0, 0, '0);
        guard = 0;
        while (!(m_active && m_post == 1) && guard < 50) begin cycle(0, 0, 1, $urandom); guard++; end
        check("pre_reset_strobe", frame_strobe != 0, 1);
        resetn = 1'b0;
        #1;
        check("rst_strobe", frame_strobe, 0);
        check("rst_mode", mode, 0);
        check("rst_data", frame_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        model_reset();
        #2 resetn = 1'b1;
        cycle(0, 0, 0, '0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom);
        // Single-row, two-frame instance: period 3, done on cycle 7
        start = 0; abort = 0; in_valid = 0;
        s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        s1_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            f = (c - 1) / 3;
            ph = (c - 1) % 3;
            es1 = (ph == 1 && f < 2) ? 2'(1 << f) : 2'b00;
            check("s1_strobe", s1_strobe, es1);
            check("s1_ready", s1_ready, ph == 0 && f < 2);
            check("s1_done", s1_done, c == 7);
            check("s1_mode", s1_mode, c <= 6);
            if (es1 != 0) check("s1_data", s1_fd, 100 + c - 1);
            s1_data = FB'(100 + c);
            @(negedge clk);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
